// File: rtl/div_pkg.sv
// Shared types and constants for the divider result stage.
package div_pkg;

  localparam int DIV_WIDTH = 8;

  // Quotient reported for a divide-by-zero; sliced down to WIDTH by users.
  localparam logic [63:0] DIV_ERR_QUOT = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CORR  = 3'd1,
    S_SIGN  = 3'd2,
    S_VALID = 3'd3,
    S_CLEAR = 3'd4
  } result_state_t;

endpackage

// File: rtl/div_negate.sv
// Conditional two's-complement negate, wrapping modulo 2^WIDTH.
module div_negate #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in,
  input  logic             neg,
  output logic [WIDTH-1:0] out
);

  assign out = neg ? (~in + WIDTH'(1)) : in;

endmodule

// File: rtl/div_result_stage.sv
// Divider output stage: captures raw core results, applies remainder
// correction and sign fix-up, hands the result off, then clears the core.
//
// state   | meaning
// S_IDLE  | waiting for core_done, captures raw results
// S_CORR  | non-restoring correction (q-1, r+d) when flagged
// S_SIGN  | sign fix-up or error substitution into output regs
// S_VALID | result presented, waiting for out_ready
// S_CLEAR | one-cycle clear pulse back to the core
module div_result_stage
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             core_done,
  input  logic             core_correct_en,
  input  logic             core_err,
  input  logic             q_neg,
  input  logic             r_neg,
  input  logic [WIDTH-1:0] q_raw,
  input  logic [WIDTH-1:0] r_raw,
  input  logic [WIDTH-1:0] d_mag,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             core_clear,
  output logic             busy
);

  result_state_t    r_state;
  result_state_t    w_next_state;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_d;
  logic             r_corr;
  logic             r_err;
  logic             r_qneg;
  logic             r_rneg;

  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic [WIDTH-1:0] w_q_signed;
  logic [WIDTH-1:0] w_r_signed;

  div_negate #(.WIDTH(WIDTH)) u_neg_q (
    .in  (r_q),
    .neg (r_qneg),
    .out (w_q_signed)
  );

  div_negate #(.WIDTH(WIDTH)) u_neg_r (
    .in  (r_r),
    .neg (r_rneg),
    .out (w_r_signed)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (core_done) w_next_state = S_CORR;
      S_CORR:  w_next_state = S_SIGN;
      S_SIGN:  w_next_state = S_VALID;
      S_VALID: if (out_ready) w_next_state = S_CLEAR;
      S_CLEAR: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q    <= '0;
      r_r    <= '0;
      r_d    <= '0;
      r_corr <= 1'b0;
      r_err  <= 1'b0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (core_done) begin
            r_q    <= q_raw;
            r_r    <= r_raw;
            r_d    <= d_mag;
            r_corr <= core_correct_en;
            r_err  <= core_err;
            r_qneg <= q_neg;
            r_rneg <= r_neg;
          end
        end
        S_CORR: begin
          if (r_corr && !r_err) begin
            r_q <= r_q - WIDTH'(1);
            r_r <= r_r + r_d;
          end
        end
        S_SIGN: begin
          // Error results skip both correction and negation.
          if (r_err) begin
            r_quot <= DIV_ERR_QUOT[WIDTH-1:0];
            r_rem  <= r_r;
            r_dbz  <= 1'b1;
          end else begin
            r_quot <= w_q_signed;
            r_rem  <= w_r_signed;
            r_dbz  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid   = (r_state == S_VALID);
  assign core_clear  = (r_state == S_CLEAR);
  assign busy        = (r_state != S_IDLE);
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_result_stage.sv
// Scoreboard bench for div_result_stage: directed operations with
// hand-computed results, latency/handshake checks and async reset mid-op.
module tb_div_result_stage;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       core_done = 1'b0;
  logic       core_correct_en = 1'b0;
  logic       core_err = 1'b0;
  logic       q_neg = 1'b0;
  logic       r_neg = 1'b0;
  logic [7:0] q_raw = '0;
  logic [7:0] r_raw = '0;
  logic [7:0] d_mag = '0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;
  logic       core_clear;
  logic       busy;

  div_result_stage #(.WIDTH(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .core_done       (core_done),
    .core_correct_en (core_correct_en),
    .core_err        (core_err),
    .q_neg           (q_neg),
    .r_neg           (r_neg),
    .q_raw           (q_raw),
    .r_raw           (r_raw),
    .d_mag           (d_mag),
    .out_ready       (out_ready),
    .out_valid       (out_valid),
    .quotient        (quotient),
    .remainder       (remainder),
    .div_by_zero     (div_by_zero),
    .core_clear      (core_clear),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic mon_prev_v = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected result on every rising out_valid.
  always @(negedge clk) begin
    if (out_valid && !mon_prev_v) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_quotient", {24'd0, quotient}, {24'd0, mon_e.q});
        chk("sb_remainder", {24'd0, remainder}, {24'd0, mon_e.r});
        chk("sb_div_by_zero", {31'd0, div_by_zero}, {31'd0, mon_e.dbz});
      end
    end
    mon_prev_v = out_valid;
  end

  task automatic run_op(input string tag,
                        input logic [7:0] q, input logic [7:0] r, input logic [7:0] d,
                        input logic corr, input logic err, input logic qn, input logic rn,
                        input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                        input int hold, input bit poke);
    exp_t e;
    e.q = eq; e.r = er; e.dbz = edbz;
    sb_q.push_back(e);
    @(negedge clk);
    q_raw = q; r_raw = r; d_mag = d;
    core_correct_en = corr; core_err = err; q_neg = qn; r_neg = rn;
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    // Scramble inputs so any late re-sampling corrupts the result.
    q_raw = ~q; r_raw = ~r; d_mag = ~d;
    core_correct_en = ~corr; core_err = ~err; q_neg = ~qn; r_neg = ~rn;
    chk({tag, "_lat1_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_lat1_busy"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk({tag, "_lat2_valid"}, {31'd0, out_valid}, 32'd0);
    if (poke) core_done = 1'b1;
    @(negedge clk);
    chk({tag, "_lat3_valid"}, {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_hold_quot"}, {24'd0, quotient}, {24'd0, eq});
      chk({tag, "_hold_rem"}, {24'd0, remainder}, {24'd0, er});
      chk({tag, "_hold_clear"}, {31'd0, core_clear}, 32'd0);
    end
    core_done = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_clr_pulse"}, {31'd0, core_clear}, 32'd1);
    chk({tag, "_clr_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_clr_quot"}, {24'd0, quotient}, {24'd0, eq});
    chk({tag, "_clr_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
    @(negedge clk);
    chk({tag, "_idle_clear"}, {31'd0, core_clear}, 32'd0);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_quot", {24'd0, quotient}, 32'd0);
    chk("rst_rem", {24'd0, remainder}, 32'd0);
    chk("rst_clear", {31'd0, core_clear}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    run_op("plain",   8'h07, 8'h03, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 8'h07, 8'h03, 1'b0, 0, 1'b0);
    run_op("corr",    8'h05, 8'hFE, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 8'h04, 8'h05, 1'b0, 0, 1'b0);
    run_op("neg",     8'h03, 8'h01, 8'h04, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFD, 8'hFF, 1'b0, 0, 1'b0);
    run_op("err",     8'h10, 8'h2A, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h2A, 1'b1, 0, 1'b0);
    run_op("hold",    8'h12, 8'h04, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 8'hEE, 8'hFC, 1'b0, 5, 1'b1);
    run_op("corrneg", 8'h0A, 8'hFD, 8'h05, 1'b1, 1'b0, 1'b1, 1'b0, 8'hF7, 8'h02, 1'b0, 0, 1'b0);
    run_op("minneg",  8'h80, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80, 8'h00, 1'b0, 1, 1'b0);

    // Async reset while the operation sits in S_SIGN; nothing is scored.
    @(negedge clk);
    q_raw = 8'h33; r_raw = 8'h11; d_mag = 8'h02;
    core_correct_en = 1'b0; core_err = 1'b0; q_neg = 1'b0; r_neg = 1'b0;
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_quot", {24'd0, quotient}, 32'd0);
    chk("arst_rem", {24'd0, remainder}, 32'd0);
    chk("arst_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("arst_clear", {31'd0, core_clear}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("arst_after_clear", {31'd0, core_clear}, 32'd0);
      chk("arst_after_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_after_busy", {31'd0, busy}, 32'd0);
    end

    run_op("after_rst", 8'h01, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h00, 1'b0, 0, 1'b0);

    @(negedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
